// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types and default sizes for the RAM arbiter.
package cpu_types_pkg;

    localparam int unsigned MEMARB_ADDR_W      = 32;
    localparam int unsigned MEMARB_DATA_W      = 32;
    localparam int unsigned MEMARB_LAT_MAX     = 15;
    localparam int unsigned MEMARB_DSTREAK_MAX = 4;

    typedef logic [MEMARB_DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2
    } memarb_state_t;

endpackage

// File: rtl/memarb_timeout.sv
// Grant wait counter: counts enabled cycles, saturates and flags expiry at LAT_MAX.
module memarb_timeout #(
    parameter int unsigned LAT_MAX = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CNT_W = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == CNT_W'(LAT_MAX));

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, data first.
// Define MEMARB_FAIR_EN to bound instruction starvation with a data-streak counter.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned ADDR_W      = MEMARB_ADDR_W,
    parameter int unsigned DATA_W      = MEMARB_DATA_W,
    parameter int unsigned LAT_MAX     = MEMARB_LAT_MAX
`ifdef MEMARB_FAIR_EN
    ,
    parameter int unsigned DSTREAK_MAX = MEMARB_DSTREAK_MAX
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  ramstate_t         ramstate,
    output logic              err
);

    memarb_state_t r_state;
    memarb_state_t w_next;
    logic          r_err;
    logic          w_err_set;
    logic          w_expired;
    logic          w_fair_i;

    memarb_timeout #(
        .LAT_MAX (LAT_MAX)
    ) u_timeout (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_clear   (r_state == IDLE),
        .i_enable  ((r_state != IDLE) && (ramstate != ACCESS)),
        .o_expired (w_expired)
    );

`ifdef MEMARB_FAIR_EN
    localparam int unsigned STREAK_W = (DSTREAK_MAX < 2) ? 1 : $clog2(DSTREAK_MAX + 1);

    logic [STREAK_W-1:0] r_streak;

    // Data grants taken while a fetch waits; forces a fetch grant once the limit is hit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_streak <= '0;
        end else if (r_state == IDLE && w_next == GRANT_I) begin
            r_streak <= '0;
        end else if (r_state == IDLE && w_next == GRANT_D && iREN &&
                     r_streak != STREAK_W'(DSTREAK_MAX)) begin
            r_streak <= r_streak + STREAK_W'(1);
        end
    end

    assign w_fair_i = iREN && (r_streak == STREAK_W'(DSTREAK_MAX));
`else
    assign w_fair_i = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    // Next state and Mealy RAM/hit outputs; everything held at zero while RST is high.
    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        ihit      = 1'b0;
        iload     = '0;
        dhit      = 1'b0;
        dload     = '0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        if (!RST) begin
            case (r_state)
                IDLE: begin
                    if (w_fair_i) begin
                        w_next = GRANT_I;
                    end else if (dREN || dWEN) begin
                        w_next = GRANT_D;
                    end else if (iREN) begin
                        w_next = GRANT_I;
                    end
                end
                GRANT_D: begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramREN   = dREN && !dWEN;
                    ramWEN   = dWEN;
                    if (dREN && dWEN) begin
                        w_err_set = 1'b1;
                    end
                    if (!(dREN || dWEN)) begin
                        w_next = IDLE;
                    end else if (ramstate == ACCESS) begin
                        dhit   = 1'b1;
                        dload  = ramload;
                        w_next = IDLE;
                    end else if (ramstate == ERROR || w_expired) begin
                        w_err_set = 1'b1;
                        w_next    = IDLE;
                    end
                end
                GRANT_I: begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (!iREN) begin
                        w_next = IDLE;
                    end else if (ramstate == ACCESS) begin
                        ihit   = 1'b1;
                        iload  = ramload;
                        w_next = IDLE;
                    end else if (ramstate == ERROR || w_expired) begin
                        w_err_set = 1'b1;
                        w_next    = IDLE;
                    end
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed per-cycle vector bench for memory_arbiter (default and MEMARB_FAIR_EN builds).
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam logic [31:0] IADDR  = 32'h0000_0040;
    localparam logic [31:0] DADDR  = 32'h0000_0100;
    localparam logic [31:0] DSTORE = 32'h0000_DEAD;
    localparam logic [31:0] RLOAD  = 32'h8C01_0004;
`ifdef MEMARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        ihit;
    logic [31:0] iload;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;
    logic        err;

    memory_arbiter dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .ihit     (ihit),
        .iload    (iload),
        .dhit     (dhit),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .err      (err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // One clock cycle: inputs driven, and the expected state (0 idle, 1 data, 2 instr), hits, err.
    typedef struct {
        logic       rst;
        logic       iren;
        logic       dren;
        logic       dwen;
        logic [1:0] rs;
        logic [1:0] st;
        logic       ih;
        logic       dh;
        logic       er;
    } vec_t;

    int   n_vec;
    int   n_miss;
    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic iren, input logic dren,
                                input logic dwen, input logic [1:0] rs, input logic [1:0] st,
                                input logic ih, input logic dh, input logic er);
        vec_t v;
        v.rst = rst; v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs;
        v.st = st; v.ih = ih; v.dh = dh; v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL vec %0d %s: got %h, expected %h", n_vec, nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [31:0] e_addr;
        logic [31:0] e_store;
        logic        e_ren;
        logic        e_wen;
        @(negedge CLK);
        RST      = v.rst;
        iREN     = v.iren;
        dREN     = v.dren;
        dWEN     = v.dwen;
        ramstate = ramstate_t'(v.rs);
        #1;
        e_addr  = 32'h0;
        e_store = 32'h0;
        e_ren   = 1'b0;
        e_wen   = 1'b0;
        if (v.st == 2'd1) begin
            e_addr  = DADDR;
            e_store = DSTORE;
            e_ren   = v.dren & ~v.dwen;
            e_wen   = v.dwen;
        end else if (v.st == 2'd2) begin
            e_addr = IADDR;
            e_ren  = 1'b1;
        end
        n_vec++;
        chk("ihit",     32'(ihit),   32'(v.ih));
        chk("iload",    iload,       v.ih ? RLOAD : 32'h0);
        chk("dhit",     32'(dhit),   32'(v.dh));
        chk("dload",    dload,       v.dh ? RLOAD : 32'h0);
        chk("ramREN",   32'(ramREN), 32'(e_ren));
        chk("ramWEN",   32'(ramWEN), 32'(e_wen));
        chk("ramaddr",  ramaddr,     e_addr);
        chk("ramstore", ramstore,    e_store);
        chk("err",      32'(err),    32'(v.er));
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        RST      = 1'b1;
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        iaddr    = IADDR;
        daddr    = DADDR;
        dstore   = DSTORE;
        ramload  = RLOAD;
        ramstate = FREE;

        //            rst i  d  w  rs    st  ih dh er
        tbl.push_back(mk(1, 0, 0, 0, 2'd0, 0, 0, 0, 0));   // reset
        tbl.push_back(mk(1, 0, 0, 0, 2'd0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'd0, 0, 0, 0, 0));   // fetch, 2 BUSY then ACCESS
        tbl.push_back(mk(0, 1, 0, 0, 2'd1, 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'd1, 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'd2, 2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 2'd0, 0, 0, 0, 0));   // write and fetch together
        tbl.push_back(mk(0, 1, 0, 1, 2'd2, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'd0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'd1, 2, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'd2, 2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2'd0, 0, 0, 0, 0));   // read withdrawn mid-grant
        tbl.push_back(mk(0, 0, 1, 0, 2'd1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'd2, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'd2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2'd0, 0, 0, 0, 0));   // reset during a BUSY grant
        tbl.push_back(mk(0, 0, 1, 0, 2'd1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 2'd1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2'd2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2'd2, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2'd0, 0, 0, 0, 0));   // RAM ERROR response
        tbl.push_back(mk(0, 0, 1, 0, 2'd3, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 2'd0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 2'd0, 0, 0, 0, 0));   // read+write together: write, err
        tbl.push_back(mk(0, 0, 1, 1, 2'd1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 2'd2, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 2'd0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 0));

        foreach (tbl[k]) apply(tbl[k]);

        // Timeout: 16 BUSY grant cycles, counter reaches LAT_MAX on the last one.
        apply(mk(0, 0, 1, 0, 2'd0, 0, 0, 0, 0));
        for (int c = 0; c < 16; c++) apply(mk(0, 0, 1, 0, 2'd1, 1, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 1));
        for (int c = 0; c < 3; c++) apply(mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 1));
        apply(mk(1, 0, 0, 0, 2'd0, 0, 0, 0, 1));
        apply(mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 0));

        // Fetch held against a continuous data stream: every 5th grant is a fetch when fair.
        for (int g = 0; g < 10; g++) begin
            logic is_i;
            is_i = FAIR && ((g % 5) == 4);
            apply(mk(0, 1, 1, 0, 2'd0, 0, 0, 0, 0));
            apply(mk(0, 1, 1, 0, 2'd2, is_i ? 2'd2 : 2'd1, is_i, !is_i, 0));
        end
        apply(mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
